// File: rtl/mult_share_pkg.sv
// Shared types, saturation limits and the saturating multiply for mult_share_arbiter.
// Optional macro MULT_SHARE_ARB_SAT_FLAG_EN adds the clamp flag to the S2 record.
package mult_share_pkg;

    localparam int PKG_DATA_WIDTH = 16;
    localparam int PKG_NUM_REQ    = 4;
    localparam int PKG_ID_WIDTH   = $clog2(PKG_NUM_REQ);

    typedef logic signed [PKG_DATA_WIDTH-1:0]   data_t;
    typedef logic signed [2*PKG_DATA_WIDTH-1:0] prod_t;
    typedef logic [PKG_ID_WIDTH-1:0]            id_t;

    typedef struct packed {
        data_t a;
        data_t b;
        id_t   id;
    } s1_t;

    typedef struct packed {
        data_t res;
        id_t   id;
`ifdef MULT_SHARE_ARB_SAT_FLAG_EN
        logic  sat;
`endif
    } s2_t;

    localparam data_t SAT_MAX = {1'b0, {(PKG_DATA_WIDTH-1){1'b1}}};
    localparam data_t SAT_MIN = {1'b1, {(PKG_DATA_WIDTH-1){1'b0}}};

    function automatic prod_t full_mul(data_t a, data_t b);
        return prod_t'(a) * prod_t'(b);
    endfunction

    // The product fits when the top W+1 bits are all copies of the sign.
    function automatic logic overflow(prod_t p);
        return !((&p[2*PKG_DATA_WIDTH-1:PKG_DATA_WIDTH-1]) ||
                 !(|p[2*PKG_DATA_WIDTH-1:PKG_DATA_WIDTH-1]));
    endfunction

    function automatic data_t sat_mul(data_t a, data_t b);
        prod_t p;
        p = full_mul(a, b);
        if (overflow(p))
            return p[2*PKG_DATA_WIDTH-1] ? SAT_MIN : SAT_MAX;
        return data_t'(p[PKG_DATA_WIDTH-1:0]);
    endfunction

    function automatic logic sat_flag(data_t a, data_t b);
        return overflow(full_mul(a, b));
    endfunction

endpackage

// File: rtl/mult_share_arbiter_rr_grant.sv
// Combinational round-robin grant: search starts one past the pointer and wraps.
module rr_grant #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    input  logic                en,
    output logic [NUM_REQ-1:0]  gnt,
    output logic [ID_WIDTH-1:0] idx
);

    always_comb begin
        logic        found;
        int unsigned cand;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = (32'(ptr) + off) % NUM_REQ;
            if (!found && req[ID_WIDTH'(cand)]) begin
                found = 1'b1;
                idx   = ID_WIDTH'(cand);
            end
        end
        if (en && found)
            gnt[idx] = 1'b1;
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin shared saturating multiplier with a two-stage pipeline and tagged response.
// Optional macro MULT_SHARE_ARB_SAT_FLAG_EN adds rsp_sat_o and sat_count_o.
module mult_share_arbiter
    import mult_share_pkg::*;
#(
    parameter int DATA_WIDTH = PKG_DATA_WIDTH,
    parameter int NUM_REQ    = PKG_NUM_REQ,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic [NUM_REQ-1:0]            req_valid_in,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_in,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_in,
    output logic [DATA_WIDTH-1:0]         rsp_data_o,
    output logic [ID_WIDTH-1:0]           rsp_id_o
`ifdef MULT_SHARE_ARB_SAT_FLAG_EN
    ,
    output logic                          rsp_sat_o,
    output logic [15:0]                   sat_count_o
`endif
);

    logic [NUM_REQ-1:0]  gnt;
    logic [ID_WIDTH-1:0] gnt_idx;
    logic [ID_WIDTH-1:0] ptr_q;
    logic                s1_valid_q;
    logic                s2_valid_q;
    logic                s1_adv;
    logic                s2_adv;
    logic                xfer;
    s1_t                 s1_q;
    s1_t                 s1_d;
    s2_t                 s2_q;
    s2_t                 s2_d;

    always_comb begin
        s2_adv = !s2_valid_q || rsp_ready_in;
        s1_adv = !s1_valid_q || s2_adv;
    end

    rr_grant #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_grant (
        .req (req_valid_in),
        .ptr (ptr_q),
        .en  (s1_adv),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    // The grant is drawn only from valid requesters, so any grant is a transfer.
    always_comb begin
        req_ready_o = gnt;
        xfer        = |gnt;
        s1_d.a      = req_a_in[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
        s1_d.b      = req_b_in[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
        s1_d.id     = gnt_idx;
    end

    always_comb begin
        s2_d.res = sat_mul(s1_q.a, s1_q.b);
        s2_d.id  = s1_q.id;
`ifdef MULT_SHARE_ARB_SAT_FLAG_EN
        s2_d.sat = sat_flag(s1_q.a, s1_q.b);
`endif
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            ptr_q      <= ID_WIDTH'(NUM_REQ - 1);
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= xfer;
                if (xfer)
                    s1_q <= s1_d;
            end
            if (xfer)
                ptr_q <= gnt_idx;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s2_valid_q <= 1'b0;
            s2_q       <= '0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q)
                s2_q <= s2_d;
        end
    end

    always_comb begin
        rsp_valid_o = s2_valid_q;
        rsp_data_o  = s2_q.res;
        rsp_id_o    = s2_q.id;
    end

`ifdef MULT_SHARE_ARB_SAT_FLAG_EN
    logic [15:0] sat_count_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            sat_count_q <= '0;
        else if (s2_valid_q && rsp_ready_in && s2_q.sat)
            sat_count_q <= sat_count_q + 16'd1;
    end

    always_comb begin
        rsp_sat_o   = s2_q.sat;
        sat_count_o = sat_count_q;
    end
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomized bench for mult_share_arbiter against a queue-based reference model.
// Honours MULT_SHARE_ARB_SAT_FLAG_EN when the design is built with it.
module tb_mult_share_arbiter;

    localparam int W   = 16;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic             clk_in = 1'b0;
    logic             rst_n_in;
    logic [N-1:0]     req_valid_in;
    logic [N-1:0]     req_ready_o;
    logic [N*W-1:0]   req_a_in;
    logic [N*W-1:0]   req_b_in;
    logic             rsp_valid_o;
    logic             rsp_ready_in;
    logic [W-1:0]     rsp_data_o;
    logic [IDW-1:0]   rsp_id_o;
`ifdef MULT_SHARE_ARB_SAT_FLAG_EN
    logic             rsp_sat_o;
    logic [15:0]      sat_count_o;
`endif

    mult_share_arbiter #(
        .DATA_WIDTH (W),
        .NUM_REQ    (N),
        .ID_WIDTH   (IDW)
    ) dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .req_valid_in (req_valid_in),
        .req_ready_o  (req_ready_o),
        .req_a_in     (req_a_in),
        .req_b_in     (req_b_in),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_in (rsp_ready_in),
        .rsp_data_o   (rsp_data_o),
        .rsp_id_o     (rsp_id_o)
`ifdef MULT_SHARE_ARB_SAT_FLAG_EN
        ,
        .rsp_sat_o    (rsp_sat_o),
        .sat_count_o  (sat_count_o)
`endif
    );

    always #5 clk_in = ~clk_in;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] res;
        int          id;
        bit          sat;
        int          elig;
    } exp_t;

    exp_t        q[$];
    int          mptr;
    int          cyc;
    int          sat_retired;
    bit          pend[N];
    logic [15:0] opa[N];
    logic [15:0] opb[N];

    // Plain integer reference: exact product, then clamp to the 16-bit range.
    function automatic logic [16:0] ref_mul(logic [15:0] a, logic [15:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        if (p > 32767)  return {1'b1, 16'h7fff};
        if (p < -32768) return {1'b1, 16'h8000};
        return {1'b0, p[15:0]};
    endfunction

    function automatic logic [15:0] rand_op();
        logic [15:0] sp[7];
        sp = '{16'h7fff, 16'h8000, 16'h0001, 16'hffff, 16'h4000, 16'hc000, 16'h0000};
        if ($urandom_range(3) == 0) return sp[$urandom_range(6)];
        return 16'($urandom);
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            req_valid_in[i]      = pend[i];
            req_a_in[i*W +: W]   = opa[i];
            req_b_in[i*W +: W]   = opb[i];
        end
    endtask

    // One clock cycle: refill idle requesters, compare, then advance the model.
    task automatic step(input bit rdy, input int pct, output logic [N-1:0] seen);
        int          g;
        bit          vis;
        logic [16:0] r;
        @(negedge clk_in);
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(99) < pct) begin
                pend[i] = 1'b1;
                opa[i]  = rand_op();
                opb[i]  = rand_op();
            end
        end
        drive_inputs();
        rsp_ready_in = rdy;
        #1;
        g = -1;
        if (q.size() < 2 || rdy) begin
            for (int k = 1; k <= N; k++) begin
                if (pend[(mptr + k) % N]) begin
                    g = (mptr + k) % N;
                    break;
                end
            end
        end
        seen = req_ready_o;
        check_eq("req_ready", 32'(req_ready_o), (g >= 0) ? (32'd1 << g) : 32'd0);
        vis = (q.size() > 0) && (cyc >= q[0].elig);
        check_eq("rsp_valid", 32'(rsp_valid_o), 32'(vis));
`ifdef MULT_SHARE_ARB_SAT_FLAG_EN
        check_eq("sat_count", 32'(sat_count_o), 32'(sat_retired & 16'hffff));
`endif
        if (vis) begin
            check_eq("rsp_data", 32'(rsp_data_o), 32'(q[0].res));
            check_eq("rsp_id", 32'(rsp_id_o), 32'(q[0].id));
`ifdef MULT_SHARE_ARB_SAT_FLAG_EN
            check_eq("rsp_sat", 32'(rsp_sat_o), 32'(q[0].sat));
`endif
            if (rdy) begin
                if (q[0].sat) sat_retired++;
                void'(q.pop_front());
            end
        end
        if (g >= 0) begin
            r = ref_mul(opa[g], opb[g]);
            q.push_back('{res: r[15:0], id: g, sat: r[16], elig: cyc + 2});
            mptr    = g;
            pend[g] = 1'b0;
        end
        cyc++;
    endtask

    task automatic do_reset();
        rst_n_in = 1'b0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        drive_inputs();
        q.delete();
        mptr        = N - 1;
        sat_retired = 0;
        #1;
        check_eq("rst_valid", 32'(rsp_valid_o), 32'd0);
        check_eq("rst_data", 32'(rsp_data_o), 32'd0);
        check_eq("rst_id", 32'(rsp_id_o), 32'd0);
`ifdef MULT_SHARE_ARB_SAT_FLAG_EN
        check_eq("rst_sat", 32'(rsp_sat_o), 32'd0);
        check_eq("rst_sat_count", 32'(sat_count_o), 32'd0);
`endif
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;
    endtask

    task automatic run_vectors(input logic [15:0] va[$], input logic [15:0] vb[$]);
        logic [N-1:0] seen;
        int           guard;
        guard = 0;
        while ((va.size() > 0 || pend[0] || q.size() > 0) && guard < 200) begin
            if (!pend[0] && va.size() > 0) begin
                pend[0] = 1'b1;
                opa[0]  = va.pop_front();
                opb[0]  = vb.pop_front();
            end
            step(1'b1, 0, seen);
            guard++;
        end
        check_eq("vec_drain", 32'(guard < 200), 32'd1);
    endtask

    initial begin
        logic [N-1:0] seen;
        logic [15:0]  va[$];
        logic [15:0]  vb[$];
        cyc          = 0;
        rsp_ready_in = 1'b0;
        req_valid_in = '0;
        req_a_in     = '0;
        req_b_in     = '0;
        for (int i = 0; i < N; i++) begin
            opa[i] = '0;
            opb[i] = '0;
        end

        // Directed operand pairs: 5 clamp, 3 fit.
        do_reset();
        va = '{16'h0003, 16'h4000, 16'h8000, 16'h8000, 16'hc000, 16'h00ff, 16'h7fff, 16'h8000};
        vb = '{16'hfffb, 16'h0002, 16'h8000, 16'h0001, 16'h0003, 16'h0002, 16'h7fff, 16'h7fff};
        run_vectors(va, vb);
`ifdef MULT_SHARE_ARB_SAT_FLAG_EN
        check_eq("sat_count_5", 32'(sat_count_o), 32'd5);
`endif
        repeat (3) step(1'b1, 0, seen);

        // All requesters held valid: grants rotate from requester 0.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 100, seen);
            check_eq("rr_order", 32'(seen), 32'd1 << (k % N));
        end

        // Fill the pipeline, stall the response port, then release.
        for (int k = 0; k < 3; k++) step(1'b0, 100, seen);
        check_eq("stall_ready", 32'(seen), 32'd0);
        for (int k = 0; k < 6; k++) step(1'b1, 0, seen);

        // Random traffic with random backpressure.
        for (int k = 0; k < 400; k++) step($urandom_range(99) < 70, $urandom_range(80), seen);

        // Asynchronous reset mid-stream with the pipeline full.
        for (int k = 0; k < 3; k++) step(1'b0, 100, seen);
        #2;
        do_reset();
        pend[0] = 1'b1; opa[0] = 16'h0005; opb[0] = 16'h0007;
        pend[2] = 1'b1; opa[2] = 16'h0100; opb[2] = 16'h0100;
        step(1'b1, 0, seen);
        check_eq("post_rst_grant", 32'(seen), 32'd1);
        for (int k = 0; k < 6; k++) step(1'b1, 0, seen);
        check_eq("idle_drained", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
